// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with 2-bit saturating counters.
// Lookup is combinational on the fetch PC; the decode-stage resolver trains the table.
module branch_predictor #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_curr,
    output logic        predicted_taken,
    output logic [15:0] predicted_target,
    input  logic        update_en,
    input  logic [15:0] update_PC,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic        pred_taken_in,
    input  logic [15:0] pred_target_in,
    output logic        mispredicted,
    output logic [15:0] recovery_PC
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 15 - INDEX_BITS;

    logic                  valid_q  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [15:0]           target_q [ENTRIES];
    logic [1:0]            cnt_q    [ENTRIES];

    logic [INDEX_BITS-1:0] look_idx;
    logic [TAG_W-1:0]      look_tag;
    logic                  look_hit;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    logic                  unused_pc_lsb;

    // Instructions are halfword aligned, so bit 0 of the fetch PC carries no information.
    assign unused_pc_lsb = PC_curr[0];

    assign look_idx = PC_curr[INDEX_BITS:1];
    assign look_tag = PC_curr[15:INDEX_BITS+1];
    assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

    assign predicted_taken  = look_hit & cnt_q[look_idx][1];
    assign predicted_target = look_hit ? target_q[look_idx] : 16'h0000;

    assign upd_idx = update_PC[INDEX_BITS:1];
    assign upd_tag = update_PC[15:INDEX_BITS+1];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign mispredicted = update_en &
                          ((pred_taken_in != actual_taken) |
                           (actual_taken & (pred_target_in != actual_target)));
    assign recovery_PC  = actual_taken ? actual_target : (update_PC + 16'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 16'h0000;
                cnt_q[i]    <= 2'b01;
            end
        end else if (update_en) begin
            if (upd_hit) begin
                if (actual_taken) begin
                    if (cnt_q[upd_idx] != 2'b11) cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'b01;
                    target_q[upd_idx] <= actual_target;
                end else if (cnt_q[upd_idx] != 2'b00) begin
                    cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'b01;
                end
            end else if (actual_taken) begin
                // Taken miss evicts whatever aliases into this slot; not-taken misses are never kept.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= actual_target;
                cnt_q[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor: each vector is one cycle,
// lookup/mispredict outputs checked before the edge that applies the update.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] PC_curr;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic        update_en;
    logic [15:0] update_PC;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        pred_taken_in;
    logic [15:0] pred_target_in;
    logic        mispredicted;
    logic [15:0] recovery_PC;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.INDEX_BITS(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC_curr          (PC_curr),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target),
        .update_en        (update_en),
        .update_PC        (update_PC),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .pred_taken_in    (pred_taken_in),
        .pred_target_in   (pred_target_in),
        .mispredicted     (mispredicted),
        .recovery_PC      (recovery_PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ue;
        logic [15:0] upc;
        logic        at;
        logic [15:0] atg;
        logic        pti;
        logic [15:0] ptg;
        logic [15:0] pc;
        logic        e_pt;
        logic [15:0] e_ptg;
        logic        e_mis;
        logic [15:0] e_rec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ue, logic [15:0] upc, logic at, logic [15:0] atg,
                                logic pti, logic [15:0] ptg, logic [15:0] pc,
                                logic e_pt, logic [15:0] e_ptg, logic e_mis, logic [15:0] e_rec);
        vec_t v;
        v.ue = ue; v.upc = upc; v.at = at; v.atg = atg; v.pti = pti; v.ptg = ptg;
        v.pc = pc; v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_mis = e_mis; v.e_rec = e_rec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        update_en      = v.ue;
        update_PC      = v.upc;
        actual_taken   = v.at;
        actual_target  = v.atg;
        pred_taken_in  = v.pti;
        pred_target_in = v.ptg;
        PC_curr        = v.pc;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " pred_taken"},  {15'd0, predicted_taken}, {15'd0, v.e_pt});
        chk({tag, " pred_target"}, predicted_target, v.e_ptg);
        chk({tag, " mispred"},     {15'd0, mispredicted}, {15'd0, v.e_mis});
        chk({tag, " recovery"},    recovery_PC, v.e_rec);
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_vec(tag, v);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0002));
        #12 rst_n = 1'b1;

        // Reset sweep: everything misses.
        for (int i = 0; i <= 8; i++) begin
            logic [15:0] pc;
            pc = (i == 8) ? 16'hFFFE : 16'(2 * i);
            @(negedge clk);
            PC_curr = pc;
            #1;
            chk($sformatf("reset pt pc=%h", pc), {15'd0, predicted_taken}, 16'h0000);
            chk($sformatf("reset tgt pc=%h", pc), predicted_target, 16'h0000);
        end

        // ue, upc, at, atg, pti, ptg, pc, e_pt, e_ptg, e_mis, e_rec
        vecs.push_back(mk(1, 16'h0010, 1, 16'h0040, 0, 16'h0000, 16'h0010, 0, 16'h0000, 1, 16'h0040)); // cold alloc cnt=10
        vecs.push_back(mk(1, 16'h0010, 1, 16'h0040, 1, 16'h0040, 16'h0010, 1, 16'h0040, 0, 16'h0040)); // ->11
        vecs.push_back(mk(1, 16'h0010, 1, 16'h0040, 1, 16'h0040, 16'h0010, 1, 16'h0040, 0, 16'h0040)); // 11 stays
        vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 16'h0012)); // ->10
        vecs.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0040, 0, 16'h0012)); // still taken
        vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 16'h0012)); // ->01
        vecs.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0040, 0, 16'h0012)); // weak NT
        vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0040, 0, 16'h0012)); // ->00
        vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0040, 0, 16'h0012)); // 00 stays
        vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0040, 0, 16'h0012)); // 00 stays
        vecs.push_back(mk(1, 16'h0010, 1, 16'h0040, 0, 16'h0000, 16'h0010, 0, 16'h0040, 1, 16'h0040)); // ->01
        vecs.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0040, 0, 16'h0012)); // proves floor was 00
        vecs.push_back(mk(1, 16'h0100, 0, 16'h0000, 1, 16'h0200, 16'h0100, 0, 16'h0000, 1, 16'h0102)); // NT miss
        vecs.push_back(mk(0, 16'h0100, 0, 16'h0000, 0, 16'h0000, 16'h0100, 0, 16'h0000, 0, 16'h0102)); // not allocated
        vecs.push_back(mk(1, 16'h0020, 1, 16'h0080, 0, 16'h0000, 16'h0020, 0, 16'h0000, 1, 16'h0080)); // alias evict
        vecs.push_back(mk(0, 16'h0020, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 16'h0000, 0, 16'h0022)); // evicted
        vecs.push_back(mk(0, 16'h0020, 0, 16'h0000, 0, 16'h0000, 16'h0020, 1, 16'h0080, 0, 16'h0022));
        vecs.push_back(mk(1, 16'h0020, 1, 16'h0090, 1, 16'h0080, 16'h0020, 1, 16'h0080, 1, 16'h0090)); // target miss
        vecs.push_back(mk(0, 16'h0020, 0, 16'h0000, 0, 16'h0000, 16'h0020, 1, 16'h0090, 0, 16'h0022));
        vecs.push_back(mk(1, 16'hFFFE, 0, 16'h0000, 1, 16'h0000, 16'hFFFE, 0, 16'h0000, 1, 16'h0000)); // wrap
        vecs.push_back(mk(0, 16'h1234, 0, 16'h0000, 1, 16'h0000, 16'h0020, 1, 16'h0090, 0, 16'h1236)); // gated
        vecs.push_back(mk(0, 16'h1234, 1, 16'h00A0, 0, 16'h0000, 16'h0021, 1, 16'h0090, 0, 16'h00A0)); // lsb ignored
        vecs.push_back(mk(1, 16'h0036, 1, 16'h0100, 0, 16'h0000, 16'h0036, 0, 16'h0000, 1, 16'h0100)); // index 3
        vecs.push_back(mk(0, 16'h0036, 0, 16'h0000, 0, 16'h0000, 16'h0036, 1, 16'h0100, 0, 16'h0038));
        vecs.push_back(mk(0, 16'h0036, 0, 16'h0000, 0, 16'h0000, 16'h0026, 0, 16'h0000, 0, 16'h0038)); // tag differs
        vecs.push_back(mk(0, 16'h0036, 0, 16'h0000, 0, 16'h0000, 16'h0020, 1, 16'h0090, 0, 16'h0038)); // idx 0 intact

        for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

        // Same-cycle lookup and update: old contents this cycle, new contents the next.
        step("conc alloc", mk(1, 16'h0010, 1, 16'h0040, 0, 16'h0000, 16'h0010, 0, 16'h0000, 1, 16'h0040));
        step("conc same",  mk(1, 16'h0010, 1, 16'h0050, 1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 16'h0050));
        step("conc next",  mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0050, 0, 16'h0012));

        // Reset asserted mid-cycle while an update is pending.
        @(negedge clk);
        drive(mk(1, 16'h0010, 1, 16'h0060, 1, 16'h0050, 16'h0010, 0, 0, 0, 0));
        #1;
        chk("pre-rst pt",  {15'd0, predicted_taken}, 16'h0001);
        chk("pre-rst tgt", predicted_target, 16'h0050);
        #1 rst_n = 1'b0;
        #1;
        chk("rst pt",  {15'd0, predicted_taken}, 16'h0000);
        chk("rst tgt", predicted_target, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        update_en = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("post-rst pt 0010",  {15'd0, predicted_taken}, 16'h0000);
        chk("post-rst tgt 0010", predicted_target, 16'h0000);
        PC_curr = 16'h0036;
        #1;
        chk("post-rst pt 0036",  {15'd0, predicted_taken}, 16'h0000);
        chk("post-rst tgt 0036", predicted_target, 16'h0000);

        // Table still trainable after reset.
        step("re-alloc", mk(1, 16'h0010, 1, 16'h0070, 0, 16'h0000, 16'h0010, 0, 16'h0000, 1, 16'h0070));
        step("re-look",  mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0070, 0, 16'h0012));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
